// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, two-cycle redirect flush, and memory-wait hold with sticky timeout.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic        x_is_load_i,
  input  logic        x_rf_wen_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_redirect_i,
  input  logic        dmem_busy_i,
  output logic        stall_pc_o,
  output logic        stall_id_o,
  output logic        bubble_x_o,
  output logic        flush_id_o,
  output logic        stall_all_o,
  output logic [1:0]  state_o,
  output logic        timeout_err_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  localparam logic [7:0] WaitLimit = 8'(WAIT_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       load_use;

  assign load_use = id_valid_i & x_is_load_i & x_rf_wen_i & (x_rd_i != 5'd0) &
                    ((id_use_rs1_i & (id_rs1_i == x_rd_i)) |
                     (id_use_rs2_i & (id_rs2_i == x_rd_i)));

  always_comb begin
    state_d     = ST_RUN;
    stall_pc_o  = 1'b0;
    stall_id_o  = 1'b0;
    bubble_x_o  = 1'b0;
    flush_id_o  = 1'b0;
    stall_all_o = 1'b0;
    case (state_q)
      // A non-busy cycle in ST_WAIT behaves exactly like ST_RUN, so a redirect held in X is not lost.
      ST_RUN, ST_WAIT: begin
        if (dmem_busy_i) begin
          stall_all_o = 1'b1;
          state_d     = ST_WAIT;
        end else if (x_redirect_i) begin
          flush_id_o = 1'b1;
          bubble_x_o = 1'b1;
          state_d    = ST_REDIR;
        end else if (load_use) begin
          stall_pc_o = 1'b1;
          stall_id_o = 1'b1;
          bubble_x_o = 1'b1;
        end
      end
      ST_REDIR: begin
        if (dmem_busy_i) begin
          stall_all_o = 1'b1;
          state_d     = ST_REDIR;
        end else begin
          flush_id_o = 1'b1;
          bubble_x_o = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst_i) begin
      state_d     = ST_RUN;
      stall_pc_o  = 1'b0;
      stall_id_o  = 1'b0;
      bubble_x_o  = 1'b0;
      flush_id_o  = 1'b0;
      stall_all_o = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d == ST_WAIT && state_q != ST_WAIT) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == ST_WAIT && stall_all_o && wait_cnt_q != 8'hFF) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    timeout_d = timeout_q | (wait_cnt_q == WaitLimit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state_o       = state_q;
  assign timeout_err_o = timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_pc_o | stall_all_o};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_id_o};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_cycles_o = flush_cnt_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_cycles_o = 32'd0;
`endif

endmodule
